// File: rtl/game_pkg.sv
// Shared board geometry, cell/index types and the row-shifter state encoding.
package game_pkg;

  localparam int unsigned BOARD_W = 10;
  localparam int unsigned BOARD_H = 20;
  localparam int unsigned CELL_W  = 3;
  localparam int unsigned X_W     = $clog2(BOARD_W);
  localparam int unsigned Y_W     = $clog2(BOARD_H);

  typedef logic [CELL_W-1:0] cell_t;
  typedef logic [X_W-1:0]    x_t;
  typedef logic [Y_W-1:0]    y_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_ZERO = 3'd3,
    ST_DONE = 3'd4
  } shift_state_t;

endpackage

// File: rtl/game_cell_counter.sv
// Column up-counter and row down-counter walking the board during a row shift.
// Exposes both current and next values so the owner can register addresses
// that line up with the state being entered.
module game_cell_counter
  import game_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_x_clr,
  input  logic i_x_inc,
  input  logic i_y_load,
  input  y_t   i_y_val,
  input  logic i_y_dec,
  output x_t   o_x,
  output x_t   o_x_nxt,
  output y_t   o_y,
  output y_t   o_y_nxt,
  output logic o_x_last,
  output logic o_y_eq_1
);

  x_t r_x;
  y_t r_y;
  x_t w_x_nxt;
  y_t w_y_nxt;

  assign o_x      = r_x;
  assign o_y      = r_y;
  assign o_x_nxt  = w_x_nxt;
  assign o_y_nxt  = w_y_nxt;
  assign o_x_last = (r_x == x_t'(BOARD_W - 1));
  assign o_y_eq_1 = (r_y == y_t'(1));

  // Next-value logic; neither counter ever steps past its bound.
  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (i_x_clr) begin
      w_x_nxt = '0;
    end else if (i_x_inc && !o_x_last) begin
      w_x_nxt = r_x + x_t'(1);
    end
    if (i_y_load) begin
      w_y_nxt = i_y_val;
    end else if (i_y_dec && (r_y != '0)) begin
      w_y_nxt = r_y - y_t'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else begin
      r_x <= w_x_nxt;
      r_y <= w_y_nxt;
    end
  end

endmodule

// File: rtl/game_row_shifter.sv
// Collapses the board above a cleared row: every row above row_y moves down one,
// row 0 is blanked, then shift_done is raised until the checker acknowledges.
module game_row_shifter
  import game_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  clear,
  input  logic  reset_shifter,
  input  y_t    row_y,
  output x_t    rd_x,
  output y_t    rd_y,
  input  cell_t rd_data,
  output logic  wr_en,
  output x_t    wr_x,
  output y_t    wr_y,
  output cell_t wr_data,
  output logic  busy,
  output logic  shift_done
);

  shift_state_t r_state;
  logic         r_wr_en;
  logic         r_busy;
  logic         r_shift_done;
  x_t           r_rd_x;
  x_t           r_wr_x;
  y_t           r_rd_y;
  y_t           r_wr_y;
  cell_t        r_wr_data;

  logic w_x_clr;
  logic w_x_inc;
  logic w_y_load;
  logic w_y_dec;
  logic w_x_last;
  logic w_y_eq_1;
  logic w_ry_oob;
  x_t   w_x;
  x_t   w_x_nxt;
  y_t   w_y;
  y_t   w_y_nxt;

  assign w_ry_oob = (32'(row_y) >= BOARD_H);

  game_cell_counter u_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .i_x_clr  (w_x_clr),
    .i_x_inc  (w_x_inc),
    .i_y_load (w_y_load),
    .i_y_val  (row_y),
    .i_y_dec  (w_y_dec),
    .o_x      (w_x),
    .o_x_nxt  (w_x_nxt),
    .o_y      (w_y),
    .o_y_nxt  (w_y_nxt),
    .o_x_last (w_x_last),
    .o_y_eq_1 (w_y_eq_1)
  );

  // Counter steering: x walks each row, y steps up the board after each row.
  always_comb begin
    w_x_clr  = 1'b0;
    w_x_inc  = 1'b0;
    w_y_load = 1'b0;
    w_y_dec  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (clear) begin
          w_x_clr  = 1'b1;
          w_y_load = !w_ry_oob && (row_y != '0);
        end
      end
      ST_WR: begin
        if (!w_x_last) begin
          w_x_inc = 1'b1;
        end else begin
          w_x_clr = 1'b1;
          w_y_dec = !w_y_eq_1;
        end
      end
      ST_ZERO: begin
        if (w_x_last) begin
          w_x_clr = 1'b1;
        end else begin
          w_x_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State machine with registered outputs set on entry to each state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_wr_en      <= 1'b0;
      r_busy       <= 1'b0;
      r_shift_done <= 1'b0;
      r_rd_x       <= '0;
      r_rd_y       <= '0;
      r_wr_x       <= '0;
      r_wr_y       <= '0;
      r_wr_data    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clear) begin
            r_busy <= 1'b1;
            if (w_ry_oob) begin
              r_state      <= ST_DONE;
              r_shift_done <= 1'b1;
            end else if (row_y == '0) begin
              r_state   <= ST_ZERO;
              r_wr_en   <= 1'b1;
              r_wr_x    <= w_x_nxt;
              r_wr_y    <= '0;
              r_wr_data <= '0;
            end else begin
              r_state <= ST_RD;
              r_rd_x  <= w_x_nxt;
              r_rd_y  <= w_y_nxt - y_t'(1);
            end
          end
        end
        ST_RD: begin
          r_state <= ST_WR;
          r_wr_en <= 1'b1;
          r_wr_x  <= w_x;
          r_wr_y  <= w_y;
        end
        ST_WR: begin
          r_wr_data <= rd_data;
          if (!w_x_last || !w_y_eq_1) begin
            // y_nxt is at least 1 here, so the source row never underflows
            r_state <= ST_RD;
            r_wr_en <= 1'b0;
            r_rd_x  <= w_x_nxt;
            r_rd_y  <= w_y_nxt - y_t'(1);
          end else begin
            r_state   <= ST_ZERO;
            r_wr_x    <= w_x_nxt;
            r_wr_y    <= '0;
            r_wr_data <= '0;
          end
        end
        ST_ZERO: begin
          if (w_x_last) begin
            r_state      <= ST_DONE;
            r_wr_en      <= 1'b0;
            r_shift_done <= 1'b1;
          end else begin
            r_wr_x <= w_x_nxt;
          end
        end
        ST_DONE: begin
          if (reset_shifter || !clear) begin
            r_state      <= ST_IDLE;
            r_shift_done <= 1'b0;
            r_busy       <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rd_x       = r_rd_x;
  assign rd_y       = r_rd_y;
  assign wr_en      = r_wr_en;
  assign wr_x       = r_wr_x;
  assign wr_y       = r_wr_y;
  assign busy       = r_busy;
  assign shift_done = r_shift_done;
  // RAM data arrives in the WR cycle itself, so it is forwarded straight through.
  assign wr_data    = (r_state == ST_WR) ? rd_data : r_wr_data;

endmodule

// File: tb/tb_game_row_shifter.sv
// Bench for game_row_shifter: 10x20 board RAM with 1-cycle read latency,
// per-cycle expected-output queue built from the shift rules, and full-board checks.
`timescale 1ns/1ps
module tb_game_row_shifter;
  import game_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  clear = 1'b0;
  logic  reset_shifter = 1'b0;
  y_t    row_y = '0;
  x_t    rd_x;
  y_t    rd_y;
  cell_t rd_data;
  logic  wr_en;
  x_t    wr_x;
  y_t    wr_y;
  cell_t wr_data;
  logic  busy;
  logic  shift_done;

  always #5 clk = ~clk;

  game_row_shifter dut (
    .clk           (clk),
    .reset         (rst_n),
    .clear         (clear),
    .reset_shifter (reset_shifter),
    .row_y         (row_y),
    .rd_x          (rd_x),
    .rd_y          (rd_y),
    .rd_data       (rd_data),
    .wr_en         (wr_en),
    .wr_x          (wr_x),
    .wr_y          (wr_y),
    .wr_data       (wr_data),
    .busy          (busy),
    .shift_done    (shift_done)
  );

  cell_t       mem       [BOARD_H][BOARD_W];
  cell_t       snap      [BOARD_H][BOARD_W];
  cell_t       exp_board [BOARD_H][BOARD_W];
  logic        init_req = 1'b0;
  int unsigned wr_cnt = 0;

  // Board RAM: synchronous write, registered read, optional pattern fill.
  always @(posedge clk) begin
    if (init_req) begin
      for (int y = 0; y < int'(BOARD_H); y++)
        for (int x = 0; x < int'(BOARD_W); x++)
          mem[y][x] <= cell_t'(y);
    end else if (wr_en && (32'(wr_y) < BOARD_H) && (32'(wr_x) < BOARD_W)) begin
      mem[wr_y][wr_x] <= wr_data;
    end
    if (wr_en) wr_cnt <= wr_cnt + 1;
    if ((32'(rd_y) < BOARD_H) && (32'(rd_x) < BOARD_W)) rd_data <= mem[rd_y][rd_x];
    else rd_data <= '0;
  end

  typedef struct {
    logic  busy;
    logic  done;
    logic  we;
    logic  chk_rd;
    x_t    rx;
    y_t    ry;
    x_t    wx;
    y_t    wy;
    cell_t wd;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic push(input logic b, input logic d, input logic we, input logic cr,
                      input x_t rx, input y_t ry, input x_t wx, input y_t wy, input cell_t wd);
    exp_t e;
    e.busy = b; e.done = d; e.we = we; e.chk_rd = cr;
    e.rx = rx; e.ry = ry; e.wx = wx; e.wy = wy; e.wd = wd;
    exp_q.push_back(e);
  endtask

  // Expected cycle-by-cycle outputs and final board, from the shift rules.
  task automatic build_exp(input int ry, input bit hold);
    if (ry < int'(BOARD_H)) begin
      for (int y = ry; y >= 1; y--)
        for (int x = 0; x < int'(BOARD_W); x++) begin
          push(1'b1, 1'b0, 1'b0, 1'b1, x_t'(x), y_t'(y - 1), '0, '0, '0);
          push(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, x_t'(x), y_t'(y), snap[y-1][x]);
        end
      for (int x = 0; x < int'(BOARD_W); x++)
        push(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, x_t'(x), '0, '0);
    end
    push(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0, '0, '0);
    if (!hold) push(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
    exp_board = snap;
    if (ry < int'(BOARD_H)) begin
      for (int y = ry; y >= 1; y--) exp_board[y] = snap[y-1];
      for (int x = 0; x < int'(BOARD_W); x++) exp_board[0][x] = '0;
    end
  endtask

  // Per-cycle comparison against the expected queue; idle cycles must not write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        chk("busy", 32'(busy), 32'(cur.busy));
        chk("shift_done", 32'(shift_done), 32'(cur.done));
        chk("wr_en", 32'(wr_en), 32'(cur.we));
        if (cur.we) begin
          chk("wr_x", 32'(wr_x), 32'(cur.wx));
          chk("wr_y", 32'(wr_y), 32'(cur.wy));
          chk("wr_data", 32'(wr_data), 32'(cur.wd));
        end
        if (cur.chk_rd) begin
          chk("rd_x", 32'(rd_x), 32'(cur.rx));
          chk("rd_y", 32'(rd_y), 32'(cur.ry));
        end
      end else begin
        chk("wr_en_quiet", 32'(wr_en), 32'd0);
      end
    end
  end

  task automatic init_board();
    @(negedge clk); init_req = 1'b1;
    @(negedge clk); init_req = 1'b0;
  endtask

  task automatic check_board();
    for (int y = 0; y < int'(BOARD_H); y++) begin
      int bad = 0;
      for (int x = 0; x < int'(BOARD_W); x++)
        if (mem[y][x] !== exp_board[y][x]) bad++;
      chk($sformatf("board_row%0d_bad_cells", y), 32'(bad), 32'd0);
    end
  endtask

  task automatic run_shift(input int ry, input bit hold, input int lat_exp, input int wr_exp);
    int k;
    int lat;
    int unsigned w0;
    @(negedge clk);
    snap = mem;
    chk("busy_at_C0", 32'(busy), 32'd0);
    clear = 1'b1;
    row_y = y_t'(ry);
    w0 = wr_cnt;
    @(posedge clk);
    build_exp(ry, hold);
    #1;
    row_y = ~row_y;
    if (!hold) clear = 1'b0;
    k = 0;
    lat = 0;
    while (1) begin
      @(negedge clk);
      k++;
      if (shift_done && lat == 0) lat = k;
      if (lat != 0 && k >= lat + (hold ? 0 : 1)) break;
      if (k > 600) begin
        chk("shift_done_timeout", 32'(k), 32'(lat_exp));
        break;
      end
    end
    #1;
    chk("latency", 32'(lat), 32'(lat_exp));
    chk("wr_pulses", 32'(wr_cnt - w0), 32'(wr_exp));
    check_board();
  endtask

  task automatic release_done(input bit ack);
    @(negedge clk); #1;
    chk("done_hold", 32'(shift_done), 32'd1);
    reset_shifter = ack;
    if (!ack) clear = 1'b0;
    @(negedge clk); #1;
    chk("rel_busy", 32'(busy), 32'd0);
    chk("rel_done", 32'(shift_done), 32'd0);
    reset_shifter = 1'b0;
    clear = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      chk("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(shift_done), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_rd_x"}, 32'(rd_x), 32'd0);
    chk({tag, "_rd_y"}, 32'(rd_y), 32'd0);
    chk({tag, "_wr_x"}, 32'(wr_x), 32'd0);
    chk({tag, "_wr_y"}, 32'(wr_y), 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
  endtask

  initial begin
    int k;
    int unsigned w0;
    #1;
    check_all_zero("reset");
    #12 rst_n = 1'b1;
    init_board();

    // Top row only: ten blanking writes, rows below untouched.
    run_shift(0, 1'b1, 11, 10);
    chk("lit_r5c2", 32'(mem[5][2]), 32'd5);
    chk("lit_r0c4", 32'(mem[0][4]), 32'd0);
    release_done(1'b1);

    // Bottom row: whole board moves down.
    init_board();
    run_shift(19, 1'b1, 391, 200);
    chk("lit_r19c0", 32'(mem[19][0]), 32'd2);
    chk("lit_r10c5", 32'(mem[10][5]), 32'd1);
    chk("lit_r1c3", 32'(mem[1][3]), 32'd0);
    release_done(1'b1);

    // Second shift after an ack exit, on the already-shifted board.
    run_shift(5, 1'b1, 111, 60);
    release_done(1'b1);

    // Out-of-range row: straight to done, no writes.
    run_shift(25, 1'b1, 1, 0);
    release_done(1'b0);

    // One-cycle clear pulse: shift completes, done for one cycle only.
    init_board();
    run_shift(3, 1'b0, 71, 40);
    chk("lit_r3c9", 32'(mem[3][9]), 32'd2);
    repeat (2) @(negedge clk);
    #1;
    chk("post_pulse_busy", 32'(busy), 32'd0);

    // Async reset in the middle of a write.
    init_board();
    @(negedge clk);
    snap = mem;
    clear = 1'b1;
    row_y = y_t'(10);
    @(posedge clk);
    build_exp(10, 1'b1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(wr_en && k >= 40) && k < 300);
    chk("reached_wr", 32'(wr_en), 32'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    clear = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    w0 = wr_cnt;
    repeat (6) begin
      @(negedge clk); #1;
      chk("after_reset_busy", 32'(busy), 32'd0);
    end
    chk("after_reset_writes", 32'(wr_cnt - w0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
